// File: rtl/poke_arb_pkg.sv
// poke_arb_pkg: shared definitions for the smem poke arbiter.
//   DATA_W             width of one row/entry/value word
//   DEF_TIMEOUT_CYCLES default watchdog limit (used with POKE_ARB_TIMEOUT_EN)
//   IDLE/START/WAIT_BUSY/WAIT_DONE  arbiter FSM encoding
//   poke_cmd_t         one latched poke command (row, entry, value)
//   next_index()       round-robin successor of an index modulo n
package poke_arb_pkg;

  localparam int DATA_W             = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  typedef struct packed {
    logic [DATA_W-1:0] row;
    logic [DATA_W-1:0] entry;
    logic [DATA_W-1:0] value;
  } poke_cmd_t;

  function automatic int next_index(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/poke_arbiter_if.sv
// poke_arbiter_if: requester-side and engine-side signals of the poke arbiter.
//   req/req_row/req_entry/req_value  NR requesters, 32-bit words packed per requester
//   ack/ack_err                      completion pulse per requester, abort qualifier
//   grant_idx/grant_valid            currently served requester, poke in flight
//   poke_row/entry/value/start/busy  poke engine connection
//   timeout_count                    saturating count of watchdog aborts
//   dbg_state                        arbiter FSM state for observation
// Handshake: a requester raises req[i] with stable data and holds both until
// ack[i] pulses for one cycle; req may stay high for one cycle after ack.
// poke_start is a one-cycle pulse; the engine holds poke_busy high while it works.
// Modports: slave = the arbiter, master = the environment (requesters + engine).
interface poke_arbiter_if #(
  parameter int NR = 3,
  parameter int IW = 3
);
  logic [NR-1:0]                      req;
  logic [NR*poke_arb_pkg::DATA_W-1:0] req_row;
  logic [NR*poke_arb_pkg::DATA_W-1:0] req_entry;
  logic [NR*poke_arb_pkg::DATA_W-1:0] req_value;
  logic [NR-1:0]                      ack;
  logic                               ack_err;
  logic [IW-1:0]                      grant_idx;
  logic                               grant_valid;
  logic [poke_arb_pkg::DATA_W-1:0]    poke_row;
  logic [poke_arb_pkg::DATA_W-1:0]    poke_entry;
  logic [poke_arb_pkg::DATA_W-1:0]    poke_value;
  logic                               poke_start;
  logic                               poke_busy;
  logic [15:0]                        timeout_count;
  logic [1:0]                         dbg_state;

  modport slave (
    input  req, req_row, req_entry, req_value, poke_busy,
    output ack, ack_err, grant_idx, grant_valid,
           poke_row, poke_entry, poke_value, poke_start,
           timeout_count, dbg_state
  );

  modport master (
    output req, req_row, req_entry, req_value, poke_busy,
    input  ack, ack_err, grant_idx, grant_valid,
           poke_row, poke_entry, poke_value, poke_start,
           timeout_count, dbg_state
  );
endinterface

// File: rtl/poke_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, reusable by smem arbiters.
//   req   NR  pending requests
//   mask  NR  requests to ignore this cycle
//   ptr   IW  highest-priority index; search runs upward from it, wrapping modulo NR
//   found 1   at least one unmasked request
//   idx   IW  first unmasked request at or after ptr (0 when none)
module rr_pick #(
  parameter int NR = 3,
  parameter int IW = 3
) (
  input  logic [NR-1:0] req,
  input  logic [NR-1:0] mask,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [NR-1:0] elig;
  assign elig = req & ~mask;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NR; k++) begin
      if (!found && elig[(int'(ptr) + k) % NR]) begin
        found = 1'b1;
        idx   = IW'((int'(ptr) + k) % NR);
      end
    end
  end

endmodule

// File: rtl/poke_arbiter.sv
// poke_arbiter: shares the single smem poke engine between NR requesters.
// Picks one pending request round-robin, drives the engine's row/entry/value
// and a one-cycle start, follows poke_busy high then low, and returns a
// one-cycle ack to the winner. All outputs are registered.
// Ports:
//   clk     system clock
//   resetn  synchronous active-low reset
//   bus     poke_arbiter_if.slave (requesters, engine, status, dbg_state)
// Optional build macro POKE_ARB_TIMEOUT_EN adds a watchdog: a poke whose
// engine does not finish within TIMEOUT_CYCLES clocks of its start pulse is
// aborted with ack + ack_err, and timeout_count increments (saturating).
// Without the macro ack_err and timeout_count are constant 0.
module poke_arbiter
  import poke_arb_pkg::*;
#(
  parameter int NR             = 3,
  parameter int IW             = 3,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic           clk,
  input logic           resetn,
  poke_arbiter_if.slave bus
);

  if (NR < 2 || NR > 8 || (1 << IW) < NR || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("poke_arbiter: illegal NR/IW/TIMEOUT_CYCLES combination");
  end

  logic [1:0]    state_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] grant_q;
  poke_cmd_t     cmd_q;
  logic [NR-1:0] ack_q;
  logic          ack_err_q;
  logic          gv_q;
  logic          start_q;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  poke_cmd_t     pick_cmd;
  logic          grant_go;
  logic          done_go;
  logic          abort_go;
  logic          wd_expire;

  // The requester acked this cycle may still hold req for one more cycle,
  // so the current ack vector doubles as the arbitration mask.
  rr_pick #(.NR(NR), .IW(IW)) u_pick (
    .req   (bus.req),
    .mask  (ack_q),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign pick_cmd = '{row:   bus.req_row  [DATA_W*int'(pick_idx) +: DATA_W],
                      entry: bus.req_entry[DATA_W*int'(pick_idx) +: DATA_W],
                      value: bus.req_value[DATA_W*int'(pick_idx) +: DATA_W]};

  // Never start a poke while the engine still reports busy.
  assign grant_go = (state_q == IDLE) && pick_found && !bus.poke_busy;
  assign done_go  = (state_q == WAIT_DONE) && !bus.poke_busy;
  // A normal completion in the same cycle as expiry wins over the abort.
  assign abort_go = wd_expire && !done_go;

`ifdef POKE_ARB_TIMEOUT_EN
  logic [31:0] wdog_q;
  logic [15:0] tcount_q;

  // wdog_q counts clocks since the start pulse (0 during START), so the abort
  // decided when it reaches TIMEOUT_CYCLES-1 puts ack on the wire exactly
  // TIMEOUT_CYCLES clocks after poke_start.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wdog_q <= '0;
    end else if (grant_go) begin
      wdog_q <= '0;
    end else if (state_q != IDLE) begin
      wdog_q <= wdog_q + 32'd1;
    end
  end

  assign wd_expire = ((state_q == WAIT_BUSY) || (state_q == WAIT_DONE)) &&
                     (wdog_q + 32'd1 == 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tcount_q <= '0;
    end else if (abort_go && (tcount_q != 16'hFFFF)) begin
      tcount_q <= tcount_q + 16'd1;
    end
  end

  assign bus.timeout_count = tcount_q;
`else
  assign wd_expire         = 1'b0;
  assign bus.timeout_count = 16'h0000;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      cmd_q     <= '0;
      ack_q     <= '0;
      ack_err_q <= 1'b0;
      gv_q      <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      ack_q     <= '0;
      ack_err_q <= 1'b0;
      start_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_go) begin
            grant_q <= pick_idx;
            cmd_q   <= pick_cmd;
            gv_q    <= 1'b1;
            start_q <= 1'b1;
            ptr_q   <= IW'(next_index(int'(pick_idx), NR));
            state_q <= START;
          end
        end
        START: begin
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!abort_go && bus.poke_busy) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // completion handled below together with the abort path
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      if (done_go || abort_go) begin
        ack_q     <= NR'(1) << grant_q;
        ack_err_q <= abort_go;
        gv_q      <= 1'b0;
        state_q   <= IDLE;
      end
    end
  end

  assign bus.ack         = ack_q;
  assign bus.ack_err     = ack_err_q;
  assign bus.grant_idx   = grant_q;
  assign bus.grant_valid = gv_q;
  assign bus.poke_row    = cmd_q.row;
  assign bus.poke_entry  = cmd_q.entry;
  assign bus.poke_value  = cmd_q.value;
  assign bus.poke_start  = start_q;
  assign bus.dbg_state   = state_q;

endmodule
